segre_pipeline_ctrl: RTL and testbench
======================================

// Module: segre_pipeline_ctrl
// PURPOSE
//  Parametrised pipeline hazard/stall controller for the Segre in-order core; successor of the fixed 5-stage controller.
//  Detects RAW hazards against N writing stages (EX..WB), with optional bypass (stall only on load-use) and forward-select outputs.
//  Handles I$ miss and D$ miss stalls, and runs an end-of-test drain FSM raising finish_test_o.
//  Sits beside the datapath; drives per-stage block (hold) and nop (bubble) controls.
// PARAMETERS
//  NUM_WR_STAGES  3             writing stages after ID; index 0=EX, 1=MEM, 2..=later (WB last)
//  REG_SIZE       5             register identifier width
//  WORD_SIZE      32            instruction width
//  BYPASS_EN      0             0: stall on any match; 1: stall only EX load-use, else forward
//  DRAIN_CYCLES   4             non-stalled cycles from finish detect to finish_test_o (>=1)
//  FINISH_INSTR   32'hfff01073  end-of-test instruction encoding
// PORTS
//  clk_i          in   1                   clock
//  rsn_i          in   1                   async reset, active low
//  ic_hit_i       in   1                   I$ hit for the IF fetch
//  dc_hit_i       in   1                   D$ hit for the MEM access (ignored if MEM not valid)
//  valid_id_i     in   1                   ID holds a valid instruction
//  decode_instr_i in   WORD_SIZE           raw instruction in ID
//  src_a_id_i     in   REG_SIZE            rs1 of ID;  use_a_i in 1: rs1 is read
//  src_b_id_i     in   REG_SIZE            rs2 of ID;  use_b_i in 1: rs2 is read
//  valid_wr_i     in   NUM_WR_STAGES       stage j valid
//  we_wr_i        in   NUM_WR_STAGES       stage j writes the register file
//  dst_wr_i       in   NUM_WR_STAGES*REG_SIZE  stage j destination, slice j
//  is_load_ex_i   in   1                   EX instruction is a load
//  block_o        out  NUM_WR_STAGES+2     hold stage k register (0=IF, 1=ID, 2+j = wr stage j)
//  nop_o          out  NUM_WR_STAGES+2     load a bubble into stage k register
//  fwd_a_o        out  FWD_W               rs1 source: 0=regfile, j+1=stage j; FWD_W=$clog2(NUM_WR_STAGES+1)
//  fwd_b_o        out  FWD_W               rs2 source, same encoding
//  finish_test_o  out  1                   registered, sticky until reset
//  stall_cnt_o    out  32                  cycles with block_o[0]=1 in RUN, saturating at 2^32-1
// BEHAVIOUR
//  Reset (async, rsn_i=0): state RUN, drain counter 0, finish_test_o=0, stall_cnt_o=0; block_o, nop_o, fwd_* all 0.
//  match_j(s) = valid_wr_i[j] & we_wr_i[j] & dst_j==s & s!=0. Register x0 never produces a hazard or forward.
//  Hazard (registered nothing, comb): BYPASS_EN=0 -> any j match on a used source; BYPASS_EN=1 -> match_0 & is_load_ex_i only.
//  Forward (BYPASS_EN=1): youngest (lowest j) match wins; fwd=j+1; else 0. BYPASS_EN=0 -> fwd_* tied 0.
//  Priority, comb, gated by valid_id_i for hazard:
//   1 mem_stall = valid_wr_i[1] & !dc_hit_i: block IF, ID, EX, MEM; nop into wr stage 2; hazard/I$ effects suppressed.
//   2 hazard & valid_id_i: block IF, ID; nop into EX.
//   3 !ic_hit_i: block IF; nop into ID (ID not blocked here by construction).
//   4 state DRAIN/DONE: block IF; nop into ID. Combines with 1-3 by OR of blocks; nop into a blocked stage is never asserted.
//  FSM: RUN -> DRAIN when valid_id_i & decode_instr_i==FINISH_INSTR & !block_o[1]; counter loads DRAIN_CYCLES-1.
//   DRAIN: counter decrements each cycle without mem_stall; at counter==0 and no mem_stall -> DONE.
//   DONE: finish_test_o=1 from the first DONE cycle; remains until reset. Finish instruction in ID while in DRAIN/DONE is ignored.
//   Finish instruction held in ID by a hazard is not detected until the hazard clears.
//  stall_cnt_o: +1 per RUN cycle with block_o[0]=1; holds at max; frozen in DRAIN/DONE.
//  Simultaneous I$ miss and mem_stall: mem_stall rule wins, ID not bubbled. Reset mid-drain returns to RUN, finish_test_o=0.
// STRUCTURE
//  segre_pkg: ctrl_state_e {RUN, DRAIN, DONE}; stage index constants IF_STG=0, ID_STG=1, EX_WR=0, MEM_WR=1; FINISH_INSTR default.
//  One sub-module segre_hazard_match: per-source comparator over NUM_WR_STAGES -> hit vector + priority-encoded fwd index; instanced for rs1, rs2.
//  Top holds priority logic, drain FSM/counter, stall counter.
// TESTING
//  1 BYPASS_EN=0, EX writes x5, ID reads x5 -> block_o=5'b00011, nop_o[2]=1; same with src=x0 -> no block.
//  2 BYPASS_EN=1, EX load to x7, ID rs2=x7 -> stall 1 cycle; EX ALU to x7 -> no stall, fwd_b_o=1; MEM and WB both x7 -> fwd=2.
//  3 ic_hit_i=0 for 3 cycles -> block_o[0]=1, nop_o[1]=1 each cycle; stall_cnt_o=3 afterwards.
//  4 dc miss with MEM valid plus I$ miss same cycle -> block_o=5'b01111, nop_o=5'b10000, nop_o[1]=0.
//  5 0xfff01073 in ID, DRAIN_CYCLES=4, one mem_stall during drain -> finish_test_o rises 5 cycles after detect, stays 1.
//  6 assert rsn_i=0 asynchronously in DRAIN -> all outputs 0 immediately; second finish instr after release re-drains.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types and constants for the Segre pipeline controller.
//   ctrl_state_e     : drain FSM states (RUN, DRAIN, DONE)
//   IF_STG/ID_STG    : block/nop bit positions of the front-end stages
//   EX_WR/MEM_WR     : indices into the writing-stage vectors
//   FINISH_INSTR_DEF : default end-of-test instruction encoding
package segre_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ctrl_state_e;

    localparam int unsigned IF_STG = 0;
    localparam int unsigned ID_STG = 1;
    localparam int unsigned EX_WR  = 0;
    localparam int unsigned MEM_WR = 1;

    localparam logic [31:0] FINISH_INSTR_DEF = 32'hfff01073;

endpackage

// File: rtl/segre_hazard_match.sv
// Compares one ID source register against every writing stage.
//   src, use_src   : source register and whether ID actually reads it
//   valid, we, dst : per-stage valid, write-enable and packed destinations
//   hit            : per-stage match (x0 and unread sources never match)
//   fwd_idx        : youngest matching stage j encoded as j+1, 0 if none
module segre_hazard_match #(
    parameter int unsigned NUM_WR_STAGES = 3,
    parameter int unsigned REG_SIZE      = 5,
    parameter int unsigned FWD_W         = 2
) (
    input  logic [REG_SIZE-1:0]               src,
    input  logic                              use_src,
    input  logic [NUM_WR_STAGES-1:0]          valid,
    input  logic [NUM_WR_STAGES-1:0]          we,
    input  logic [NUM_WR_STAGES*REG_SIZE-1:0] dst,
    output logic [NUM_WR_STAGES-1:0]          hit,
    output logic [FWD_W-1:0]                  fwd_idx
);

    // Per-stage comparators
    always_comb begin
        hit = '0;
        for (int j = 0; j < NUM_WR_STAGES; j++) begin
            hit[j] = use_src & (src != '0) & valid[j] & we[j]
                   & (dst[j*REG_SIZE +: REG_SIZE] == src);
        end
    end

    // Scan oldest to youngest so the lowest matching index is left standing
    always_comb begin
        fwd_idx = '0;
        for (int j = NUM_WR_STAGES - 1; j >= 0; j--) begin
            if (hit[j]) begin
                fwd_idx = FWD_W'(j + 1);
            end
        end
    end

endmodule

// File: rtl/segre_pipeline_ctrl.sv
// Hazard/stall controller for the Segre in-order core.
//   clk_i, rsn_i           : clock, async active-low reset
//   ic_hit_i, dc_hit_i     : cache hit indications for IF fetch / MEM access
//   valid_id_i, decode_instr_i, src_*_id_i, use_*_i : ID stage instruction info
//   valid_wr_i, we_wr_i, dst_wr_i, is_load_ex_i     : writing stages EX..WB
//   block_o, nop_o         : per-stage hold / bubble (0=IF, 1=ID, 2+j=wr stage j)
//   fwd_a_o, fwd_b_o       : operand source select (0=regfile, j+1=wr stage j)
//   finish_test_o          : sticky end-of-test flag after drain
//   stall_cnt_o            : saturating count of IF-blocked cycles while running
module segre_pipeline_ctrl
    import segre_pkg::*;
#(
    parameter int unsigned          NUM_WR_STAGES = 3,
    parameter int unsigned          REG_SIZE      = 5,
    parameter int unsigned          WORD_SIZE     = 32,
    parameter bit                   BYPASS_EN     = 1'b0,
    parameter int unsigned          DRAIN_CYCLES  = 4,
    parameter logic [WORD_SIZE-1:0] FINISH_INSTR  = WORD_SIZE'(FINISH_INSTR_DEF),
    localparam int unsigned         FWD_W         = $clog2(NUM_WR_STAGES + 1),
    localparam int unsigned         NUM_STG       = NUM_WR_STAGES + 2
) (
    input  logic                              clk_i,
    input  logic                              rsn_i,
    input  logic                              ic_hit_i,
    input  logic                              dc_hit_i,
    input  logic                              valid_id_i,
    input  logic [WORD_SIZE-1:0]              decode_instr_i,
    input  logic [REG_SIZE-1:0]               src_a_id_i,
    input  logic                              use_a_i,
    input  logic [REG_SIZE-1:0]               src_b_id_i,
    input  logic                              use_b_i,
    input  logic [NUM_WR_STAGES-1:0]          valid_wr_i,
    input  logic [NUM_WR_STAGES-1:0]          we_wr_i,
    input  logic [NUM_WR_STAGES*REG_SIZE-1:0] dst_wr_i,
    input  logic                              is_load_ex_i,
    output logic [NUM_STG-1:0]                block_o,
    output logic [NUM_STG-1:0]                nop_o,
    output logic [FWD_W-1:0]                  fwd_a_o,
    output logic [FWD_W-1:0]                  fwd_b_o,
    output logic                              finish_test_o,
    output logic [31:0]                       stall_cnt_o
);

    localparam int unsigned EX_STG   = 2 + EX_WR;
    localparam int unsigned MEM_STG  = 2 + MEM_WR;
    localparam int unsigned POST_STG = MEM_STG + 1;
    localparam int unsigned DRAIN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [NUM_WR_STAGES-1:0] hit_a;
    logic [NUM_WR_STAGES-1:0] hit_b;
    logic [FWD_W-1:0]         fidx_a;
    logic [FWD_W-1:0]         fidx_b;
    logic                     hazard;
    logic                     mem_stall;
    logic                     finish_seen;
    logic [NUM_STG-1:0]       block_c;
    logic [NUM_STG-1:0]       nop_pre;

    ctrl_state_e              state_q;
    logic [DRAIN_W-1:0]       drain_q;
    logic                     finish_q;
    logic [31:0]              stall_q;

    segre_hazard_match #(
        .NUM_WR_STAGES (NUM_WR_STAGES),
        .REG_SIZE      (REG_SIZE),
        .FWD_W         (FWD_W)
    ) u_match_a (
        .src     (src_a_id_i),
        .use_src (use_a_i),
        .valid   (valid_wr_i),
        .we      (we_wr_i),
        .dst     (dst_wr_i),
        .hit     (hit_a),
        .fwd_idx (fidx_a)
    );

    segre_hazard_match #(
        .NUM_WR_STAGES (NUM_WR_STAGES),
        .REG_SIZE      (REG_SIZE),
        .FWD_W         (FWD_W)
    ) u_match_b (
        .src     (src_b_id_i),
        .use_src (use_b_i),
        .valid   (valid_wr_i),
        .we      (we_wr_i),
        .dst     (dst_wr_i),
        .hit     (hit_b),
        .fwd_idx (fidx_b)
    );

    // Stall priority: D$ miss, then RAW hazard, then I$ miss; drain holds IF on top
    always_comb begin
        block_c   = '0;
        nop_pre   = '0;
        mem_stall = valid_wr_i[MEM_WR] & ~dc_hit_i;
        if (BYPASS_EN) begin
            hazard = is_load_ex_i & (hit_a[EX_WR] | hit_b[EX_WR]);
        end else begin
            hazard = (|hit_a) | (|hit_b);
        end

        if (mem_stall) begin
            block_c[IF_STG]  = 1'b1;
            block_c[ID_STG]  = 1'b1;
            block_c[EX_STG]  = 1'b1;
            block_c[MEM_STG] = 1'b1;
            nop_pre[POST_STG] = 1'b1;
        end else if (hazard && valid_id_i) begin
            block_c[IF_STG] = 1'b1;
            block_c[ID_STG] = 1'b1;
            nop_pre[EX_STG] = 1'b1;
        end else if (!ic_hit_i) begin
            block_c[IF_STG] = 1'b1;
            nop_pre[ID_STG] = 1'b1;
        end

        if (state_q != RUN) begin
            block_c[IF_STG] = 1'b1;
            nop_pre[ID_STG] = 1'b1;
        end

        finish_seen = valid_id_i & (decode_instr_i == FINISH_INSTR) & ~block_c[ID_STG];
    end

    // Stage controls follow reset immediately, without waiting for a clock edge
    assign block_o       = rsn_i ? block_c : '0;
    assign nop_o         = rsn_i ? (nop_pre & ~block_c) : '0;
    assign fwd_a_o       = (BYPASS_EN && rsn_i) ? fidx_a : '0;
    assign fwd_b_o       = (BYPASS_EN && rsn_i) ? fidx_b : '0;
    assign finish_test_o = finish_q;
    assign stall_cnt_o   = stall_q;

    // Drain FSM, drain counter and stall counter
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q  <= RUN;
            drain_q  <= '0;
            finish_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (block_c[IF_STG] && (stall_q != 32'hFFFF_FFFF)) begin
                        stall_q <= stall_q + 32'd1;
                    end
                    if (finish_seen) begin
                        state_q <= DRAIN;
                        drain_q <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (!mem_stall) begin
                        if (drain_q == '0) begin
                            state_q  <= DONE;
                            finish_q <= 1'b1;
                        end else begin
                            drain_q <= drain_q - DRAIN_W'(1);
                        end
                    end
                end
                DONE: begin
                    finish_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segre_pipeline_ctrl.sv
// Self-checking bench for segre_pipeline_ctrl: one instance without bypass,
// one with bypass, shared stimulus, checked against a behavioural model
// every cycle plus hand-computed literal expectations.
module tb_segre_pipeline_ctrl;

    localparam int N  = 3;
    localparam int R  = 5;
    localparam int W  = 32;
    localparam int DC = 4;
    localparam int FW = 2;
    localparam int S  = N + 2;
    localparam logic [W-1:0] FIN = 32'hfff01073;

    logic           clk = 1'b0;
    logic           rsn_i = 1'b0;
    logic           ic_hit_i = 1'b1;
    logic           dc_hit_i = 1'b1;
    logic           valid_id_i = 1'b0;
    logic [W-1:0]   decode_instr_i = '0;
    logic [R-1:0]   src_a_id_i = '0;
    logic           use_a_i = 1'b0;
    logic [R-1:0]   src_b_id_i = '0;
    logic           use_b_i = 1'b0;
    logic [N-1:0]   valid_wr_i = '0;
    logic [N-1:0]   we_wr_i = '0;
    logic [N*R-1:0] dst_wr_i = '0;
    logic           is_load_ex_i = 1'b0;

    logic [S-1:0]   d_blk [2];
    logic [S-1:0]   d_nop [2];
    logic [FW-1:0]  d_fa  [2];
    logic [FW-1:0]  d_fb  [2];
    logic           d_fin [2];
    logic [31:0]    d_cnt [2];

    int checks = 0;
    int errors = 0;

    // model state per instance: mode 0=running, 1=draining, 2=finished
    int          m_mode [2] = '{0, 0};
    int          m_left [2] = '{0, 0};
    logic        m_fin  [2] = '{1'b0, 1'b0};
    logic [31:0] m_cnt  [2] = '{32'd0, 32'd0};

    always #5 clk = ~clk;

    segre_pipeline_ctrl #(
        .NUM_WR_STAGES(N), .REG_SIZE(R), .WORD_SIZE(W), .BYPASS_EN(1'b0),
        .DRAIN_CYCLES(DC), .FINISH_INSTR(FIN)
    ) u_dut0 (
        .clk_i(clk), .rsn_i(rsn_i), .ic_hit_i(ic_hit_i), .dc_hit_i(dc_hit_i),
        .valid_id_i(valid_id_i), .decode_instr_i(decode_instr_i),
        .src_a_id_i(src_a_id_i), .use_a_i(use_a_i), .src_b_id_i(src_b_id_i), .use_b_i(use_b_i),
        .valid_wr_i(valid_wr_i), .we_wr_i(we_wr_i), .dst_wr_i(dst_wr_i), .is_load_ex_i(is_load_ex_i),
        .block_o(d_blk[0]), .nop_o(d_nop[0]), .fwd_a_o(d_fa[0]), .fwd_b_o(d_fb[0]),
        .finish_test_o(d_fin[0]), .stall_cnt_o(d_cnt[0])
    );

    segre_pipeline_ctrl #(
        .NUM_WR_STAGES(N), .REG_SIZE(R), .WORD_SIZE(W), .BYPASS_EN(1'b1),
        .DRAIN_CYCLES(DC), .FINISH_INSTR(FIN)
    ) u_dut1 (
        .clk_i(clk), .rsn_i(rsn_i), .ic_hit_i(ic_hit_i), .dc_hit_i(dc_hit_i),
        .valid_id_i(valid_id_i), .decode_instr_i(decode_instr_i),
        .src_a_id_i(src_a_id_i), .use_a_i(use_a_i), .src_b_id_i(src_b_id_i), .use_b_i(use_b_i),
        .valid_wr_i(valid_wr_i), .we_wr_i(we_wr_i), .dst_wr_i(dst_wr_i), .is_load_ex_i(is_load_ex_i),
        .block_o(d_blk[1]), .nop_o(d_nop[1]), .fwd_a_o(d_fa[1]), .fwd_b_o(d_fb[1]),
        .finish_test_o(d_fin[1]), .stall_cnt_o(d_cnt[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic mhit(input logic [R-1:0] s, input logic u, input int j);
        logic [R-1:0] d;
        d = dst_wr_i[j*R +: R];
        return u && (s != '0) && valid_wr_i[j] && we_wr_i[j] && (d == s);
    endfunction

    // Number of leading stages (from IF) that are held this cycle; the
    // bubble goes into the first stage behind the held ones.
    function automatic int depth(input int b);
        logic haz;
        int   d;
        haz = 1'b0;
        if (b == 1) begin
            haz = is_load_ex_i && (mhit(src_a_id_i, use_a_i, 0) || mhit(src_b_id_i, use_b_i, 0));
        end else begin
            for (int j = 0; j < N; j++)
                haz = haz || mhit(src_a_id_i, use_a_i, j) || mhit(src_b_id_i, use_b_i, j);
        end
        if (valid_wr_i[1] && !dc_hit_i)  d = 4;
        else if (haz && valid_id_i)      d = 2;
        else if (!ic_hit_i)              d = 1;
        else                             d = 0;
        if (m_mode[b] != 0 && d < 1) d = 1;
        return d;
    endfunction

    function automatic logic [FW-1:0] mfwd(input int b, input logic [R-1:0] s, input logic u);
        int pick;
        pick = 0;
        if (b == 1) begin
            for (int j = 0; j < N; j++)
                if (pick == 0 && mhit(s, u, j)) pick = j + 1;
        end
        return FW'(pick);
    endfunction

    always @(posedge clk or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int b = 0; b < 2; b++) begin
                m_mode[b] = 0; m_left[b] = 0; m_fin[b] = 1'b0; m_cnt[b] = '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                int  d;
                logic ms;
                d  = depth(b);
                ms = valid_wr_i[1] && !dc_hit_i;
                if (m_mode[b] == 0) begin
                    if (d >= 1 && m_cnt[b] != 32'hFFFF_FFFF) m_cnt[b] = m_cnt[b] + 1;
                    if (valid_id_i && decode_instr_i == FIN && d < 2) begin
                        m_mode[b] = 1;
                        m_left[b] = DC;
                    end
                end else if (m_mode[b] == 1) begin
                    if (!ms) begin
                        m_left[b] = m_left[b] - 1;
                        if (m_left[b] == 0) begin
                            m_mode[b] = 2;
                            m_fin[b]  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            logic [S-1:0]  eb;
            logic [S-1:0]  en;
            logic [FW-1:0] ea;
            logic [FW-1:0] ef;
            int            d;
            eb = '0; en = '0; ea = '0; ef = '0;
            if (rsn_i) begin
                d = depth(b);
                for (int k = 0; k < d; k++) eb[k] = 1'b1;
                if (d > 0) en[d] = 1'b1;
                ea = mfwd(b, src_a_id_i, use_a_i);
                ef = mfwd(b, src_b_id_i, use_b_i);
            end
            chk($sformatf("model dut%0d block", b), d_blk[b], eb);
            chk($sformatf("model dut%0d nop", b), d_nop[b], en);
            chk($sformatf("model dut%0d fwd_a", b), d_fa[b], ea);
            chk($sformatf("model dut%0d fwd_b", b), d_fb[b], ef);
            chk($sformatf("model dut%0d finish", b), d_fin[b], m_fin[b]);
            chk($sformatf("model dut%0d stall_cnt", b), d_cnt[b], m_cnt[b]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        ic_hit_i = 1'b1; dc_hit_i = 1'b1; valid_id_i = 1'b0; decode_instr_i = '0;
        src_a_id_i = '0; use_a_i = 1'b0; src_b_id_i = '0; use_b_i = 1'b0;
        valid_wr_i = '0; we_wr_i = '0; dst_wr_i = '0; is_load_ex_i = 1'b0;
    endtask

    task automatic wr(input int j, input logic [R-1:0] d);
        valid_wr_i[j] = 1'b1;
        we_wr_i[j]    = 1'b1;
        dst_wr_i[j*R +: R] = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle();
        rsn_i = 1'b0;
        nxt();
        rsn_i = 1'b1;
    endtask

    initial begin
        idle();
        nxt(); nxt();
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            chk("reset block", d_blk[b], 0);
            chk("reset nop", d_nop[b], 0);
            chk("reset finish", d_fin[b], 0);
            chk("reset stall_cnt", d_cnt[b], 0);
        end
        nxt();
        rsn_i = 1'b1;

        // RAW on rs1 from EX, then the same against x0
        idle(); valid_id_i = 1'b1; use_a_i = 1'b1; src_a_id_i = 5'd5; wr(0, 5'd5);
        @(negedge clk);
        chk("raw nobyp block", d_blk[0], 5'b00011);
        chk("raw nobyp nop", d_nop[0], 5'b00100);
        chk("raw byp block", d_blk[1], 5'b00000);
        chk("raw byp fwd_a", d_fa[1], 1);
        nxt();
        src_a_id_i = 5'd0; wr(0, 5'd0);
        @(negedge clk);
        chk("x0 nobyp block", d_blk[0], 5'b00000);
        chk("x0 byp fwd_a", d_fa[1], 0);
        nxt();

        // Load-use then forwarding choices on rs2
        idle(); valid_id_i = 1'b1; use_b_i = 1'b1; src_b_id_i = 5'd7; wr(0, 5'd7); is_load_ex_i = 1'b1;
        @(negedge clk);
        chk("load-use byp block", d_blk[1], 5'b00011);
        chk("load-use byp nop", d_nop[1], 5'b00100);
        nxt();
        idle(); valid_id_i = 1'b1; use_b_i = 1'b1; src_b_id_i = 5'd7; wr(1, 5'd7);
        @(negedge clk);
        chk("after load byp block", d_blk[1], 5'b00000);
        chk("after load fwd_b", d_fb[1], 2);
        nxt();
        idle(); valid_id_i = 1'b1; use_b_i = 1'b1; src_b_id_i = 5'd7; wr(0, 5'd7);
        @(negedge clk);
        chk("alu ex byp block", d_blk[1], 5'b00000);
        chk("alu ex fwd_b", d_fb[1], 1);
        nxt();
        idle(); valid_id_i = 1'b1; use_b_i = 1'b1; src_b_id_i = 5'd7; wr(1, 5'd7); wr(2, 5'd7);
        @(negedge clk);
        chk("mem+wb fwd_b", d_fb[1], 2);
        chk("mem+wb nobyp block", d_blk[0], 5'b00011);
        nxt();

        // Three I$ misses from a clean counter
        pulse_reset();
        ic_hit_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("icmiss block", d_blk[0], 5'b00001);
            chk("icmiss nop", d_nop[1], 5'b00010);
            nxt();
        end
        ic_hit_i = 1'b1;
        @(negedge clk);
        chk("icmiss cnt0", d_cnt[0], 3);
        chk("icmiss cnt1", d_cnt[1], 3);
        nxt();

        // D$ miss with MEM valid together with an I$ miss
        valid_wr_i[1] = 1'b1; dc_hit_i = 1'b0; ic_hit_i = 1'b0;
        @(negedge clk);
        chk("dmiss block", d_blk[0], 5'b01111);
        chk("dmiss nop", d_nop[0], 5'b10000);
        chk("dmiss byp nop", d_nop[1], 5'b10000);
        nxt();

        // Finish drain with one mem stall in the middle
        idle(); valid_id_i = 1'b1; decode_instr_i = FIN;
        nxt();
        idle();
        @(negedge clk);
        chk("drain block", d_blk[0], 5'b00001);
        chk("drain nop", d_nop[0], 5'b00010);
        nxt();
        nxt();
        valid_wr_i[1] = 1'b1; dc_hit_i = 1'b0;
        @(negedge clk);
        chk("drain dmiss block", d_blk[0], 5'b01111);
        chk("drain dmiss nop", d_nop[0], 5'b10000);
        nxt();
        idle();
        nxt();
        @(negedge clk);
        chk("finish early", d_fin[0], 0);
        nxt();
        valid_id_i = 1'b1; decode_instr_i = FIN;
        @(negedge clk);
        chk("finish rise", d_fin[0], 1);
        chk("finish rise byp", d_fin[1], 1);
        chk("done cnt frozen", d_cnt[0], 4);
        chk("done block", d_blk[0], 5'b00001);
        chk("done nop", d_nop[0], 5'b00010);
        nxt(); nxt();
        @(negedge clk);
        chk("finish sticky", d_fin[0], 1);
        nxt();

        // Asynchronous reset in the middle of a drain
        pulse_reset();
        valid_id_i = 1'b1; decode_instr_i = FIN;
        nxt();
        idle(); valid_id_i = 1'b1; use_a_i = 1'b1; src_a_id_i = 5'd5; wr(0, 5'd5);
        #2;
        rsn_i = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            chk("async rst block", d_blk[b], 0);
            chk("async rst nop", d_nop[b], 0);
            chk("async rst fwd_a", d_fa[b], 0);
            chk("async rst finish", d_fin[b], 0);
        end
        nxt();
        rsn_i = 1'b1;
        idle(); valid_id_i = 1'b1; decode_instr_i = FIN;
        nxt();
        idle();
        nxt(); nxt(); nxt();
        @(negedge clk);
        chk("redrain early", d_fin[0], 0);
        nxt();
        @(negedge clk);
        chk("redrain rise", d_fin[0], 1);
        chk("redrain rise byp", d_fin[1], 1);
        nxt();

        // Finish instruction held in ID by a hazard (non-bypass only)
        pulse_reset();
        valid_id_i = 1'b1; decode_instr_i = FIN; use_a_i = 1'b1; src_a_id_i = 5'd5; wr(0, 5'd5);
        @(negedge clk);
        chk("held finish block", d_blk[0], 5'b00011);
        nxt(); nxt();
        valid_wr_i = '0; we_wr_i = '0; dst_wr_i = '0;
        nxt();
        idle();
        for (int i = 0; i < 8; i++) nxt();
        @(negedge clk);
        chk("held finish dut0", d_fin[0], 1);
        chk("held finish dut1", d_fin[1], 1);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
